// File: rtl/vcop_issue.sv
// Scalar-side issue unit for the vector coprocessor: budget-timed hold of one vector op.
// Optional macro VCOP_BACK2BACK_EN lets the next vector op follow the last held cycle directly.
module vcop_issue #(
   parameter int unsigned LAT_CFG  = 1,
   parameter int unsigned LAT_ALU  = 2,
   parameter int unsigned LAT_MUL  = 4,
   parameter int unsigned LAT_RED  = 8,
   parameter int unsigned LAT_SLDU = 4,
   parameter int unsigned LAT_LD   = 3,
   parameter int unsigned LAT_ST   = 3,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        id_valid,
   input  logic [31:0] id_instr,
   output logic        id_stall,
   output logic [4:0]  rf_raddr1,
   output logic [4:0]  rf_raddr2,
   input  logic [31:0] rf_rdata1,
   input  logic [31:0] rf_rdata2,
   output logic [31:0] op_instr_base,
   output logic [31:0] xreg_out1,
   output logic [31:0] xreg_out2,
   output logic        vbusy,
   output logic        vdone,
   output logic [1:0]  dbg_state
);

   // Handshake: an ID instruction advances on a rising edge when id_valid=1 and id_stall=0;
   // a vector instruction is accepted on exactly that edge, and only from IDLE (or the
   // last held cycle when back-to-back issue is enabled).

   localparam logic [6:0] OPC_OPV = 7'b1010111;
   localparam logic [6:0] OPC_LD  = 7'b0000111;
   localparam logic [6:0] OPC_ST  = 7'b0100111;

   localparam logic [3:0] L_CFG  = 4'(LAT_CFG);
   localparam logic [3:0] L_ALU  = 4'(LAT_ALU);
   localparam logic [3:0] L_MUL  = 4'(LAT_MUL);
   localparam logic [3:0] L_RED  = 4'(LAT_RED);
   localparam logic [3:0] L_SLDU = 4'(LAT_SLDU);
   localparam logic [3:0] L_LD   = 4'(LAT_LD);
   localparam logic [3:0] L_ST   = 4'(LAT_ST);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  cnt;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [5:0]  funct6;
   logic        is_opv;
   logic        is_vec;
   logic        is_opm;
   logic        accept;
   logic        last_cycle;
   logic [3:0]  lat;
   logic        unused_instr_bits;

   assign opcode = id_instr[6:0];
   assign funct3 = id_instr[14:12];
   assign funct6 = id_instr[31:26];

   assign is_opv = (opcode == OPC_OPV);
   assign is_vec = is_opv || (opcode == OPC_LD) || (opcode == OPC_ST);
   assign is_opm = (funct3 == 3'b010) || (funct3 == 3'b110);

   assign rf_raddr1 = id_instr[19:15];
   assign rf_raddr2 = id_instr[24:20];

   // vd and vm do not influence issue timing
   assign unused_instr_bits = ^{id_instr[11:7], id_instr[25]};

   assign last_cycle = (state == ST_EXEC) && (cnt == 4'd0);
   assign dbg_state  = state;

   // Latency class, highest priority first: memory, config, multiply, reduction, slide, ALU
   always_comb begin
      lat = L_ALU;
      if (opcode == OPC_LD) begin
         lat = L_LD;
      end else if (opcode == OPC_ST) begin
         lat = L_ST;
      end else if (funct3 == 3'b111) begin
         lat = L_CFG;
      end else if (is_opm && (funct6[5:3] == 3'b100)) begin
         lat = L_MUL;
      end else if (is_opm && (funct6[5:3] == 3'b000)) begin
         lat = L_RED;
      end else if ((funct6 == 6'b001110) || (funct6 == 6'b001111)) begin
         lat = L_SLDU;
      end
   end

   assign accept = id_valid && is_vec;

   always_comb begin
      id_stall = 1'b0;
      case (state)
         ST_IDLE:  id_stall = 1'b0;
`ifdef VCOP_BACK2BACK_EN
         ST_EXEC:  id_stall = id_valid && !last_cycle;
`else
         ST_EXEC:  id_stall = id_valid;
`endif
         ST_DRAIN: id_stall = id_valid;
         default:  id_stall = 1'b0;
      endcase
   end

   // vdone is registered against the value cnt is about to take, so it lines up with cnt==0
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state         <= ST_IDLE;
         cnt           <= 4'd0;
         op_instr_base <= NOP;
         xreg_out1     <= 32'd0;
         xreg_out2     <= 32'd0;
         vbusy         <= 1'b0;
         vdone         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               vdone <= 1'b0;
               if (accept) begin
                  state         <= ST_EXEC;
                  cnt           <= lat - 4'd1;
                  op_instr_base <= id_instr;
                  xreg_out1     <= rf_rdata1;
                  xreg_out2     <= rf_rdata2;
                  vbusy         <= 1'b1;
                  vdone         <= (lat == 4'd1);
               end
            end
            ST_EXEC: begin
               if (cnt != 4'd0) begin
                  cnt   <= cnt - 4'd1;
                  vdone <= (cnt == 4'd1);
               end else begin
`ifdef VCOP_BACK2BACK_EN
                  if (accept) begin
                     state         <= ST_EXEC;
                     cnt           <= lat - 4'd1;
                     op_instr_base <= id_instr;
                     xreg_out1     <= rf_rdata1;
                     xreg_out2     <= rf_rdata2;
                     vbusy         <= 1'b1;
                     vdone         <= (lat == 4'd1);
                  end else begin
                     state         <= ST_IDLE;
                     op_instr_base <= NOP;
                     vbusy         <= 1'b0;
                     vdone         <= 1'b0;
                  end
`else
                  state         <= ST_DRAIN;
                  op_instr_base <= NOP;
                  vbusy         <= 1'b0;
                  vdone         <= 1'b0;
`endif
               end
            end
            ST_DRAIN: begin
               state <= ST_IDLE;
               vdone <= 1'b0;
            end
            default: begin
               state         <= ST_IDLE;
               cnt           <= 4'd0;
               op_instr_base <= NOP;
               vbusy         <= 1'b0;
               vdone         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vcop_issue.sv
// Directed + randomized bench for vcop_issue against a cycle-level model of the issue rules.
// Build with +define+VCOP_BACK2BACK_EN to exercise the back-to-back variant.
module tb_vcop_issue;

   localparam logic [31:0] NOP_W = 32'h0000_0013;
`ifdef VCOP_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   logic        clk;
   logic        nrst;
   logic        id_valid;
   logic [31:0] id_instr;
   logic        id_stall;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic [31:0] op_instr_base;
   logic [31:0] xreg_out1;
   logic [31:0] xreg_out2;
   logic        vbusy;
   logic        vdone;
   logic [1:0]  dbg_state;

   int checks;
   int errors;
   int stall_cnt;

   vcop_issue dut (
      .clk           (clk),
      .nrst          (nrst),
      .id_valid      (id_valid),
      .id_instr      (id_instr),
      .id_stall      (id_stall),
      .rf_raddr1     (rf_raddr1),
      .rf_raddr2     (rf_raddr2),
      .rf_rdata1     (rf_rdata1),
      .rf_rdata2     (rf_rdata2),
      .op_instr_base (op_instr_base),
      .xreg_out1     (xreg_out1),
      .xreg_out2     (xreg_out2),
      .vbusy         (vbusy),
      .vdone         (vdone),
      .dbg_state     (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Hold budget straight from the instruction class table
   function automatic int ref_lat(input logic [31:0] w);
      logic [6:0] op;
      logic [2:0] f3;
      logic [5:0] f6;
      bit         opm;
      op  = w[6:0];
      f3  = w[14:12];
      f6  = w[31:26];
      opm = (f3 == 3'b010) || (f3 == 3'b110);
      if (op == 7'b0000111) return 3;
      if (op == 7'b0100111) return 3;
      if (f3 == 3'b111) return 1;
      if (opm && f6[5:3] == 3'b100) return 4;
      if (opm && f6[5:3] == 3'b000) return 8;
      if (f6 == 6'b001110 || f6 == 6'b001111) return 4;
      return 2;
   endfunction

   function automatic logic [31:0] rand_scalar();
      logic [31:0] w;
      logic [6:0]  ops [4];
      ops[0] = 7'b0010011;
      ops[1] = 7'b0110011;
      ops[2] = 7'b0000011;
      ops[3] = 7'b1100011;
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 3)];
      return w;
   endfunction

   function automatic logic [31:0] rand_vec();
      logic [31:0] w;
      int sel;
      w = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0)      w[6:0] = 7'b0000111;
      else if (sel == 1) w[6:0] = 7'b0100111;
      else               w[6:0] = 7'b1010111;
      sel = $urandom_range(0, 4);
      if (sel == 1)      w[31:26] = 6'b001110;
      else if (sel == 2) w[31:26] = 6'b001111;
      else if (sel == 3) w[31:29] = 3'b100;
      else if (sel == 4) w[31:29] = 3'b000;
      return w;
   endfunction

   // driver tasks: each consumes one rising edge, drives at +1, checks at +2
   task automatic accept_cycle(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      id_valid  = 1'b1;
      id_instr  = instr;
      rf_rdata1 = a;
      rf_rdata2 = b;
      #1;
      check("accept_stall", id_stall, 0);
      check("accept_op_nop", op_instr_base, NOP_W);
      check("accept_vbusy", vbusy, 0);
      check("accept_raddr1", rf_raddr1, instr[19:15]);
      check("accept_raddr2", rf_raddr2, instr[24:20]);
   endtask

   task automatic hold(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                       input bit force_valid, input bit chain,
                       input logic [31:0] nxt, input logic [31:0] na, input logic [31:0] nb);
      int l;
      l = ref_lat(instr);
      for (int k = 1; k <= l; k++) begin
         @(posedge clk); #1;
         if (k == l && chain) begin
            id_valid  = 1'b1;
            id_instr  = nxt;
            rf_rdata1 = na;
            rf_rdata2 = nb;
         end else begin
            id_valid  = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
            id_instr  = rand_scalar();
            rf_rdata1 = $urandom;
            rf_rdata2 = $urandom;
         end
         #1;
         if (id_stall) stall_cnt++;
         check("hold_op", op_instr_base, instr);
         check("hold_x1", xreg_out1, a);
         check("hold_x2", xreg_out2, b);
         check("hold_vbusy", vbusy, 1);
         check("hold_vdone", vdone, (k == l));
         check("hold_stall", id_stall, (k == l && B2B) ? 1'b0 : id_valid);
      end
   endtask

   // cycle after the last held cycle: DRAIN bubble, or IDLE when back-to-back is on
   task automatic post(input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      id_valid  = 1'b1;
      id_instr  = rand_scalar();
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      #1;
      if (id_stall) stall_cnt++;
      check("post_op_nop", op_instr_base, NOP_W);
      check("post_vbusy", vbusy, 0);
      check("post_vdone", vdone, 0);
      check("post_x1", xreg_out1, a);
      check("post_x2", xreg_out2, b);
      check("post_stall", id_stall, B2B ? 1'b0 : 1'b1);
   endtask

   task automatic idle_scalar(input logic [31:0] instr);
      @(posedge clk); #1;
      id_valid  = 1'b1;
      id_instr  = instr;
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      #1;
      check("idle_stall", id_stall, 0);
      check("idle_op_nop", op_instr_base, NOP_W);
      check("idle_vbusy", vbusy, 0);
      check("idle_vdone", vdone, 0);
   endtask

   logic [31:0] vadd_w, vsetvli_w, vmul_w, vred_w, vle_w, vse_w, vslide_w, addi_w, w;
   logic [31:0] a, b;

   initial begin
      checks    = 0;
      errors    = 0;
      stall_cnt = 0;
      vadd_w    = 32'h0220_81D7;
      vsetvli_w = {1'b0, 11'h0D0, 5'd10, 3'b111, 5'd5, 7'b1010111};
      vmul_w    = {6'b100101, 1'b1, 5'd2, 5'd1, 3'b010, 5'd3, 7'b1010111};
      vred_w    = {6'b000000, 1'b1, 5'd4, 5'd5, 3'b010, 5'd6, 7'b1010111};
      vle_w     = {3'b000, 1'b0, 2'b00, 1'b1, 5'd0, 5'd11, 3'b110, 5'd8, 7'b0000111};
      vse_w     = {3'b000, 1'b0, 2'b00, 1'b1, 5'd0, 5'd12, 3'b110, 5'd8, 7'b0100111};
      vslide_w  = {6'b001110, 1'b1, 5'd2, 5'd3, 3'b100, 5'd1, 7'b1010111};
      addi_w    = 32'h00A0_0093;

      // reset state
      nrst      = 1'b0;
      id_valid  = 1'b0;
      id_instr  = 32'h0;
      rf_rdata1 = 32'h0;
      rf_rdata2 = 32'h0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_op", op_instr_base, NOP_W);
      check("rst_x1", xreg_out1, 0);
      check("rst_x2", xreg_out2, 0);
      check("rst_vbusy", vbusy, 0);
      check("rst_vdone", vdone, 0);
      check("rst_stall", id_stall, 0);
      @(negedge clk);
      nrst = 1'b1;

      // scalar instructions in IDLE pass untouched
      idle_scalar(addi_w);
      idle_scalar(rand_scalar());
      idle_scalar(rand_scalar());

      // vadd.vv, rs 5/7: two held cycles then one NOP cycle
      accept_cycle(vadd_w, 32'd5, 32'd7);
      hold(vadd_w, 32'd5, 32'd7, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      post(32'd5, 32'd7);
      idle_scalar(addi_w);

      // vsetvli: single held cycle carries vdone
      accept_cycle(vsetvli_w, 32'h40, 32'h0);
      hold(vsetvli_w, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      post(32'h40, 32'h0);
      idle_scalar(rand_scalar());

      // vredsum with a scalar add waiting in ID
      accept_cycle(vred_w, 32'hDEAD_BEEF, 32'h1234_5678);
      stall_cnt = 0;
      hold(vred_w, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      post(32'hDEAD_BEEF, 32'h1234_5678);
      check("red_stall_cycles", stall_cnt, B2B ? 32'd7 : 32'd9);
      idle_scalar(32'h0020_8033);

      // slide
      accept_cycle(vslide_w, 32'd3, 32'd9);
      hold(vslide_w, 32'd3, 32'd9, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      post(32'd3, 32'd9);

      // vle32 then vse32
`ifdef VCOP_BACK2BACK_EN
      accept_cycle(vle_w, 32'h1000, 32'h0);
      hold(vle_w, 32'h1000, 32'h0, 1'b1, 1'b1, vse_w, 32'h2000, 32'h4);
      hold(vse_w, 32'h2000, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      post(32'h2000, 32'h4);
`else
      accept_cycle(vle_w, 32'h1000, 32'h0);
      hold(vle_w, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      post(32'h1000, 32'h0);
      accept_cycle(vse_w, 32'h2000, 32'h4);
      hold(vse_w, 32'h2000, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
      post(32'h2000, 32'h4);
`endif
      idle_scalar(addi_w);

      // reset in held cycle 2 of vmul aborts without vdone
      accept_cycle(vmul_w, 32'd11, 32'd13);
      @(posedge clk); #1;
      id_valid = 1'b0;
      #1;
      check("mul_h1_op", op_instr_base, vmul_w);
      check("mul_h1_vdone", vdone, 0);
      @(posedge clk); #1;
      nrst = 1'b0;
      #1;
      check("mulrst_op", op_instr_base, NOP_W);
      check("mulrst_vbusy", vbusy, 0);
      check("mulrst_vdone", vdone, 0);
      check("mulrst_x1", xreg_out1, 0);
      @(posedge clk); #1;
      nrst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #2;
         check("after_rst_vdone", vdone, 0);
         check("after_rst_vbusy", vbusy, 0);
         check("after_rst_op", op_instr_base, NOP_W);
      end

      // randomized mix of scalar and vector traffic
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle_scalar(rand_scalar());
         end else begin
            w = rand_vec();
            a = $urandom;
            b = $urandom;
            accept_cycle(w, a, b);
            hold(w, a, b, 1'($urandom_range(0, 1)), 1'b0, 32'h0, 32'h0, 32'h0);
            post(a, b);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
